// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I_Zicsr pipeline.
// Drives fetch/decode stall and flush, the execute operand forwarding selects,
// serialises SYSTEM instructions behind a pipeline drain, and counts bubbles.
module pipeline_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [6:0]  i_id_opcode,
    input  logic [4:0]  i_id_rs1_addr,
    input  logic [4:0]  i_id_rs2_addr,
    input  logic [6:0]  i_ex_opcode,
    input  logic [4:0]  i_ex_rd_addr,
    input  logic        i_ex_wr_en,
    input  logic [4:0]  i_mem_rd_addr,
    input  logic        i_mem_wr_en,
    input  logic        i_br_taken,
    output logic        o_stall,
    output logic        o_flush,
    output logic [1:0]  o_fwd_a,
    output logic [1:0]  o_fwd_b,
    output logic [31:0] o_bubble_cnt
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] FLUSH_RELOAD = 3'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);
    localparam logic [2:0] DRAIN_RELOAD = 3'(DRAIN_CYCLES - 1);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2,
        ISSUE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] bubble_q, bubble_d;

    logic        stall, flush;
    logic        load_use;
    logic        ex_fwd_ok, mem_fwd_ok;
    logic [1:0]  fwd_a, fwd_b;

    // A load in execute cannot forward yet; any consumer in decode must wait a cycle.
    always_comb begin
        load_use = (i_ex_opcode == OP_LOAD) && i_ex_wr_en && (i_ex_rd_addr != 5'd0) &&
                   ((i_ex_rd_addr == i_id_rs1_addr) || (i_ex_rd_addr == i_id_rs2_addr));
    end

    // Forwarding selects; the younger EX result takes precedence over MEM.
    always_comb begin
        ex_fwd_ok  = i_ex_wr_en && (i_ex_rd_addr != 5'd0) && (i_ex_opcode != OP_LOAD);
        mem_fwd_ok = i_mem_wr_en && (i_mem_rd_addr != 5'd0);
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (ex_fwd_ok && (i_ex_rd_addr == i_id_rs1_addr))
            fwd_a = FWD_EX;
        else if (mem_fwd_ok && (i_mem_rd_addr == i_id_rs1_addr))
            fwd_a = FWD_MEM;
        if (ex_fwd_ok && (i_ex_rd_addr == i_id_rs2_addr))
            fwd_b = FWD_EX;
        else if (mem_fwd_ok && (i_mem_rd_addr == i_id_rs2_addr))
            fwd_b = FWD_MEM;
    end

    // Next state and stall/flush; a redirect overrides everything, then drain, then load-use.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        flush   = 1'b0;
        if (i_br_taken) begin
            flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                cnt_d   = FLUSH_RELOAD;
            end else begin
                state_d = RUN;
            end
        end else begin
            unique case (state_q)
                RUN: begin
                    if (i_id_opcode == OP_SYSTEM) begin
                        stall   = 1'b1;
                        state_d = DRAIN;
                        cnt_d   = DRAIN_RELOAD;
                    end else if (load_use) begin
                        stall = 1'b1;
                    end
                end
                FLUSH: begin
                    flush = 1'b1;
                    if (cnt_q == 3'd0) state_d = RUN;
                    else               cnt_d   = cnt_q - 3'd1;
                end
                DRAIN: begin
                    stall = 1'b1;
                    if (cnt_q == 3'd0) state_d = ISSUE;
                    else               cnt_d   = cnt_q - 3'd1;
                end
                ISSUE: begin
                    // The SYSTEM op passes now; a load-use stall holds it here one more cycle.
                    if (load_use) stall   = 1'b1;
                    else          state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Saturating bubble counter for the performance CSRs.
    always_comb begin
        bubble_d = bubble_q;
        if ((stall || flush) && (bubble_q != 32'hFFFF_FFFF))
            bubble_d = bubble_q + 32'd1;
    end

    // State, drain/flush counter and bubble count registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= RUN;
            cnt_q    <= 3'd0;
            bubble_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bubble_q <= bubble_d;
        end
    end

    // Control outputs are held quiet while reset is asserted.
    always_comb begin
        o_stall = i_rst_n ? stall : 1'b0;
        o_flush = i_rst_n ? flush : 1'b0;
        o_fwd_a = i_rst_n ? fwd_a : FWD_RF;
        o_fwd_b = i_rst_n ? fwd_b : FWD_RF;
    end

    assign o_bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with FLUSH_CYCLES=2, DRAIN_CYCLES=3.
module tb_pipeline_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [6:0]  i_id_opcode;
    logic [4:0]  i_id_rs1_addr, i_id_rs2_addr;
    logic [6:0]  i_ex_opcode;
    logic [4:0]  i_ex_rd_addr;
    logic        i_ex_wr_en;
    logic [4:0]  i_mem_rd_addr;
    logic        i_mem_wr_en;
    logic        i_br_taken;
    logic        o_stall, o_flush;
    logic [1:0]  o_fwd_a, o_fwd_b;
    logic [31:0] o_bubble_cnt;

    int tests = 0;
    int fails = 0;
    int exp_bub = 0;

    localparam logic [6:0] LOAD = 7'b0000011;
    localparam logic [6:0] SYS  = 7'b1110011;
    localparam logic [6:0] ALU  = 7'b0110011;

    pipeline_ctrl #(.FLUSH_CYCLES(2), .DRAIN_CYCLES(3)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_id_opcode(i_id_opcode), .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
        .i_ex_opcode(i_ex_opcode), .i_ex_rd_addr(i_ex_rd_addr), .i_ex_wr_en(i_ex_wr_en),
        .i_mem_rd_addr(i_mem_rd_addr), .i_mem_wr_en(i_mem_wr_en), .i_br_taken(i_br_taken),
        .o_stall(o_stall), .o_flush(o_flush), .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b),
        .o_bubble_cnt(o_bubble_cnt)
    );

    always #5 i_clk = ~i_clk;

    // Inputs change 1 time unit after posedge; outputs are checked 1 unit later.
    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_id_opcode = 7'd0; i_id_rs1_addr = 5'd0; i_id_rs2_addr = 5'd0;
        i_ex_opcode = 7'd0; i_ex_rd_addr = 5'd0; i_ex_wr_en = 1'b0;
        i_mem_rd_addr = 5'd0; i_mem_wr_en = 1'b0; i_br_taken = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            i_id_opcode = (i % 2 == 0) ? SYS : LOAD;
            i_id_rs1_addr = 5'd3; i_id_rs2_addr = 5'd3;
            i_ex_opcode = (i % 2 == 0) ? ALU : LOAD;
            i_ex_rd_addr = 5'd3; i_ex_wr_en = 1'b1;
            i_mem_rd_addr = 5'd3; i_mem_wr_en = 1'b1;
            i_br_taken = i[0];
            #1;
            tests++;
            if ({o_stall, o_flush, o_fwd_a, o_fwd_b} !== 6'd0) begin
                fails++;
                $display("FAIL reset_outputs cyc%0d: got %b want 000000", i, {o_stall, o_flush, o_fwd_a, o_fwd_b});
            end
            next_cycle();
        end
        idle();
        i_rst_n = 1'b1;
        #1;
        tests++;
        if (o_bubble_cnt !== 32'd0) begin
            fails++;
            $display("FAIL reset_bubble: got %0d want 0", o_bubble_cnt);
        end
        exp_bub = 0;
        next_cycle();
    endtask

    task automatic test_load_use();
        i_ex_opcode = LOAD; i_ex_rd_addr = 5'd5; i_ex_wr_en = 1'b1; i_id_rs2_addr = 5'd5;
        #1;
        tests++;
        if (o_stall !== 1'b1 || o_flush !== 1'b0 || o_fwd_b !== 2'b00) begin
            fails++;
            $display("FAIL load_use: got stall=%b flush=%b fwd_b=%b want 1 0 00", o_stall, o_flush, o_fwd_b);
        end
        exp_bub++;
        next_cycle();
        // Bubble now in execute.
        i_ex_opcode = 7'd0; i_ex_wr_en = 1'b0; i_ex_rd_addr = 5'd0;
        #1;
        tests++;
        if (o_stall !== 1'b0 || o_bubble_cnt !== 32'd1) begin
            fails++;
            $display("FAIL load_use_after: got stall=%b bub=%0d want 0 1", o_stall, o_bubble_cnt);
        end
        next_cycle();
        // Load writing x0 never stalls.
        i_ex_opcode = LOAD; i_ex_rd_addr = 5'd0; i_ex_wr_en = 1'b1; i_id_rs1_addr = 5'd0; i_id_rs2_addr = 5'd0;
        #1;
        tests++;
        if (o_stall !== 1'b0) begin
            fails++;
            $display("FAIL load_x0: got stall=%b want 0", o_stall);
        end
        next_cycle();
        idle();
    endtask

    task automatic test_forward();
        i_ex_opcode = ALU; i_ex_rd_addr = 5'd7; i_ex_wr_en = 1'b1;
        i_mem_rd_addr = 5'd7; i_mem_wr_en = 1'b1; i_id_rs1_addr = 5'd7; i_id_rs2_addr = 5'd9;
        #1;
        tests++;
        if (o_fwd_a !== 2'b01 || o_fwd_b !== 2'b00 || o_stall !== 1'b0) begin
            fails++;
            $display("FAIL fwd_ex_wins: got a=%b b=%b stall=%b want 01 00 0", o_fwd_a, o_fwd_b, o_stall);
        end
        i_ex_rd_addr = 5'd0; i_mem_rd_addr = 5'd0; i_id_rs1_addr = 5'd0;
        #1;
        tests++;
        if (o_fwd_a !== 2'b00) begin
            fails++;
            $display("FAIL fwd_x0: got a=%b want 00", o_fwd_a);
        end
        i_ex_rd_addr = 5'd4; i_ex_wr_en = 1'b0; i_mem_rd_addr = 5'd4; i_id_rs1_addr = 5'd4; i_id_rs2_addr = 5'd4;
        #1;
        tests++;
        if (o_fwd_a !== 2'b10 || o_fwd_b !== 2'b10) begin
            fails++;
            $display("FAIL fwd_mem: got a=%b b=%b want 10 10", o_fwd_a, o_fwd_b);
        end
        // EX is a load: it cannot forward, MEM supplies rs1 and decode stalls.
        i_ex_opcode = LOAD; i_ex_wr_en = 1'b1; i_ex_rd_addr = 5'd4; i_id_rs2_addr = 5'd1;
        #1;
        tests++;
        if (o_fwd_a !== 2'b10 || o_fwd_b !== 2'b00 || o_stall !== 1'b1) begin
            fails++;
            $display("FAIL fwd_load_ex: got a=%b b=%b stall=%b want 10 00 1", o_fwd_a, o_fwd_b, o_stall);
        end
        exp_bub++;
        next_cycle();
        idle();
    endtask

    task automatic test_redirect();
        logic [3:0] got;
        // Single pulse: flush for 2 cycles, then quiet.
        got = '0;
        for (int c = 0; c < 4; c++) begin
            i_br_taken = (c == 0);
            #1;
            got[c] = o_flush;
            if (o_flush) exp_bub++;
            next_cycle();
        end
        tests++;
        if (got !== 4'b0011) begin
            fails++;
            $display("FAIL redirect_single: got %b want 0011", got);
        end
        // Second pulse in the second flush cycle extends by 2 more cycles.
        got = '0;
        for (int c = 0; c < 4; c++) begin
            i_br_taken = (c == 0 || c == 1);
            #1;
            got[c] = o_flush;
            if (o_flush) exp_bub++;
            next_cycle();
        end
        tests++;
        if (got !== 4'b0111) begin
            fails++;
            $display("FAIL redirect_double: got %b want 0111", got);
        end
        idle();
    endtask

    task automatic test_system();
        logic [5:0] got;
        got = '0;
        i_id_opcode = SYS;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) i_id_opcode = 7'd0;
            #1;
            got[c] = o_stall;
            if (o_stall) exp_bub++;
            next_cycle();
        end
        tests++;
        if (got !== 6'b001111) begin
            fails++;
            $display("FAIL system_drain: got %b want 001111", got);
        end
        tests++;
        if (o_bubble_cnt !== 32'(exp_bub)) begin
            fails++;
            $display("FAIL bubble_mid: got %0d want %0d", o_bubble_cnt, exp_bub);
        end
        idle();
    endtask

    task automatic test_drain_abort();
        i_id_opcode = SYS;
        next_cycle();              // RUN detect
        next_cycle();              // DRAIN 1
        exp_bub += 2;
        i_br_taken = 1'b1;         // DRAIN 2
        #1;
        tests++;
        if (o_stall !== 1'b0 || o_flush !== 1'b1) begin
            fails++;
            $display("FAIL abort_now: got stall=%b flush=%b want 0 1", o_stall, o_flush);
        end
        exp_bub++;
        next_cycle();
        i_br_taken = 1'b0;
        #1;
        tests++;
        if (o_stall !== 1'b0 || o_flush !== 1'b1) begin
            fails++;
            $display("FAIL abort_flush_state: got stall=%b flush=%b want 0 1", o_stall, o_flush);
        end
        exp_bub++;
        next_cycle();
        i_id_opcode = 7'd0;
        #1;
        tests++;
        if (o_stall !== 1'b0 || o_flush !== 1'b0) begin
            fails++;
            $display("FAIL abort_run: got stall=%b flush=%b want 0 0", o_stall, o_flush);
        end
        next_cycle();
        tests++;
        if (o_bubble_cnt !== 32'(exp_bub)) begin
            fails++;
            $display("FAIL bubble_total: got %0d want %0d", o_bubble_cnt, exp_bub);
        end
        idle();
    endtask

    task automatic test_reset_mid_drain();
        i_id_opcode = SYS;
        next_cycle();
        next_cycle();              // now in DRAIN
        i_rst_n = 1'b0;
        #1;
        tests++;
        if (o_stall !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_out: got stall=%b want 0", o_stall);
        end
        next_cycle();
        i_rst_n = 1'b1;
        idle();
        #1;
        tests++;
        if (o_stall !== 1'b0 || o_flush !== 1'b0 || o_bubble_cnt !== 32'd0) begin
            fails++;
            $display("FAIL rst_mid_after: got stall=%b flush=%b bub=%0d want 0 0 0", o_stall, o_flush, o_bubble_cnt);
        end
        next_cycle();
        // Back in RUN: a fresh SYSTEM op must be detected immediately.
        i_id_opcode = SYS;
        #1;
        tests++;
        if (o_stall !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_run: got stall=%b want 1", o_stall);
        end
        next_cycle();
        idle();
    endtask

    initial begin
        idle();
        i_rst_n = 1'b0;
        #1;
        test_reset();
        test_load_use();
        test_forward();
        test_redirect();
        test_system();
        test_drain_abort();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the 5-stage RV32I_Zicsr pipeline. It watches the instruction entering decode and the instructions in execute and memory. From these it drives the shared `i_stall`/`i_flush` inputs of fetch and decode, and the forwarding selects of the execute operand muxes. It also serialises SYSTEM (CSR) instructions by draining the pipeline before issue, and keeps a bubble-cycle counter for the Zicsr performance CSRs.

## Interface
Parameters:
- FLUSH_CYCLES, 2, consecutive cycles `o_flush` is held after a redirect (1..7).
- DRAIN_CYCLES, 3, stall cycles inserted before a SYSTEM instruction issues (1..7).

Ports:
- i_clk  in  1  CPU clock.
- i_rst_n  in  1  reset, synchronous, active-low; clock i_clk.
- i_id_opcode  in  7  opcode of the instruction currently presented to decode.
- i_id_rs1_addr  in  5  rs1 field of that instruction.
- i_id_rs2_addr  in  5  rs2 field of that instruction.
- i_ex_opcode  in  7  opcode registered by decode, now in execute.
- i_ex_rd_addr  in  5  rd of the execute-stage instruction.
- i_ex_wr_en  in  1  write enable of the execute-stage instruction.
- i_mem_rd_addr  in  5  rd of the memory-stage instruction.
- i_mem_wr_en  in  1  write enable of the memory-stage instruction.
- i_br_taken  in  1  taken branch, JAL or JALR resolved in execute this cycle.
- o_stall  out  1  hold fetch PC and insert a bubble out of decode.
- o_flush  out  1  squash fetch/decode contents.
- o_fwd_a  out  2  rs1 operand select: 00 regfile, 01 EX result, 10 MEM result.
- o_fwd_b  out  2  rs2 operand select, same encoding as `o_fwd_a`.
- o_bubble_cnt  out  32  saturating count of cycles with `o_stall` or `o_flush` high.

## Operation
- State register with four states: RUN, FLUSH, DRAIN, ISSUE. It holds a 3-bit down-counter `cnt`.
- Reset (`i_rst_n` low at posedge): state is RUN, `cnt` is 0, `o_bubble_cnt` is 0. While `i_rst_n` is low, `o_stall`, `o_flush`, `o_fwd_a` and `o_fwd_b` are forced to 0.
- `o_stall`, `o_flush`, `o_fwd_a` and `o_fwd_b` are combinational from the state and the current inputs. State, `cnt` and `o_bubble_cnt` update at posedge.
- Priority in every state: `i_br_taken` > SYSTEM drain > load-use.
- Redirect:
  - `i_br_taken`=1 in any state gives `o_flush`=1 and `o_stall`=0 that cycle.
  - If FLUSH_CYCLES>1, next state is FLUSH with `cnt`=FLUSH_CYCLES-2; otherwise next state is RUN.
- FLUSH state:
  - `o_flush`=1.
  - If `cnt`==0, go to RUN; else `cnt` decrements.
  - A new `i_br_taken` reloads `cnt`.
- SYSTEM drain:
  - In RUN, `i_id_opcode`==1110011 gives `o_stall`=1, and the next state is DRAIN with `cnt`=DRAIN_CYCLES-1.
  - DRAIN state: `o_stall`=1. If `cnt`==0, go to ISSUE; else `cnt` decrements.
  - ISSUE state: `o_stall`=0 for exactly one cycle so the SYSTEM instruction passes. Then go to RUN. A SYSTEM opcode seen in ISSUE does not retrigger a drain.
- Load-use:
  - Condition (RUN or ISSUE): `i_ex_opcode`==0000011, `i_ex_wr_en`=1, `i_ex_rd_addr`!=0, and `i_ex_rd_addr` equals `i_id_rs1_addr` or `i_id_rs2_addr`.
  - This gives `o_stall`=1 for that cycle only. The state is unchanged.
  - The bubble it inserts clears the execute-stage match, so the stall lasts exactly one cycle.
- Forwarding (per operand, x = rs1 or rs2):
  - 01 when `i_ex_wr_en`, `i_ex_rd_addr`!=0, `i_ex_rd_addr`==x, and `i_ex_opcode`!=0000011.
  - Otherwise 10 when `i_mem_wr_en`, `i_mem_rd_addr`!=0 and `i_mem_rd_addr`==x.
  - Otherwise 00. The EX match wins when both EX and MEM match.
- Bubble counter: +1 each cycle with (`o_stall` or `o_flush`) and `i_rst_n`=1. It saturates at 0xFFFFFFFF and does not wrap.

## Timing
- Redirect: `o_flush` is high in the cycle of `i_br_taken` plus FLUSH_CYCLES-1 following cycles.
- SYSTEM: `o_stall` is high for DRAIN_CYCLES+1 cycles (the RUN detection cycle plus DRAIN_CYCLES cycles in DRAIN), then low in ISSUE.
- Load-use: stall has zero-cycle latency and lasts one cycle.
- Forwarding selects: zero-cycle latency.
- Reset mid-FLUSH or mid-DRAIN: the next cycle is RUN with all outputs 0.
- `i_br_taken` during DRAIN aborts the drain and enters FLUSH. The SYSTEM instruction is squashed.

## Test plan
- Reset with all inputs toggling -> outputs 0 during reset; `o_bubble_cnt`=0 after.
- `i_ex_opcode`=0000011, `i_ex_rd_addr`=5, `i_ex_wr_en`=1, `i_id_rs2_addr`=5 -> `o_stall`=1 for one cycle; `o_fwd_b`=00 that cycle; `o_bubble_cnt`=1.
- `i_ex_rd_addr`=`i_mem_rd_addr`=7, both writes enabled, EX opcode 0110011, `i_id_rs1_addr`=7 -> `o_fwd_a`=01. Same with rd=0 -> `o_fwd_a`=00.
- One-cycle pulse on `i_br_taken` with FLUSH_CYCLES=2 -> `o_flush` high for exactly 2 cycles. A second pulse in cycle 2 -> 2 more cycles after it.
- `i_id_opcode`=1110011 held, DRAIN_CYCLES=3 -> `o_stall` high for 4 cycles, low for 1 (ISSUE), no retrigger.
- `i_br_taken` in the second DRAIN cycle -> `o_stall`=0, `o_flush`=1 immediately; state FLUSH.
